// File: rtl/segmento_decod_estado_if.sv
// Segment-line bundle between a 7-segment state display and its decoder.
// The master drives the segment lines; the slave (decoder) returns the decoded state.
interface segmento_decod_estado_if;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       e;
    logic       f;
    logic       g;
    logic       ch7;
    logic       ch6;
    logic       valid;
    logic       chg;
    logic [7:0] err_cnt;

    modport master (
        output a, b, c, d, e, f, g,
        input  ch7, ch6, valid, chg, err_cnt
    );

    modport slave (
        input  a, b, c, d, e, f, g,
        output ch7, ch6, valid, chg, err_cnt
    );
endinterface

// File: rtl/segmento_decod_estado.sv
// Deglitching decoder turning a steady 7-segment game-state letter (blank, P, A)
// back into its on/off and mode bits, with a saturating illegal-pattern counter.
module segmento_decod_estado #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    segmento_decod_estado_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_OFF = 2'b00,
        ST_POS = 2'b01,
        ST_ATK = 2'b10,
        ST_INV = 2'b11
    } state_t;

    localparam logic [6:0]       SEG_OFF    = 7'b0000000;
    localparam logic [6:0]       SEG_POS    = 7'b1100111;
    localparam logic [6:0]       SEG_ATK    = 7'b1110111;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [7:0]       ERR_MAX    = 8'hFF;

    function automatic state_t decode_seg(input logic [6:0] seg);
        state_t st;
        case (seg)
            SEG_OFF: st = ST_OFF;
            SEG_POS: st = ST_POS;
            SEG_ATK: st = ST_ATK;
            default: st = ST_INV;
        endcase
        return st;
    endfunction

    logic [6:0]       w_seg;
    logic [6:0]       r_seg_q;
    logic [6:0]       r_cand;
    logic [6:0]       w_cand_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load;
    logic             w_commit;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_chg;
    logic             w_chg_nxt;
    logic [7:0]       r_err_cnt;
    logic [7:0]       w_err_nxt;

    assign w_seg = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};

    // Candidate tracking: restart the run on any change, count up to the threshold.
    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        w_load     = 1'b0;
        if (r_seg_q != r_cand) begin
            w_load     = 1'b1;
            w_cand_nxt = r_seg_q;
            w_cnt_nxt  = CNT_ONE;
        end else if (r_cnt < CNT_STABLE) begin
            w_cnt_nxt  = r_cnt + CNT_ONE;
        end else begin
            w_cnt_nxt  = r_cnt;
        end
    end

    // Commit exactly once per stable run; a fresh load also counts so a threshold of 1 commits at load.
    always_comb begin
        w_commit    = (w_cnt_nxt == CNT_STABLE) && (w_load || (r_cnt != CNT_STABLE));
        w_state_nxt = r_state;
        w_chg_nxt   = 1'b0;
        w_err_nxt   = r_err_cnt;
        if (w_commit) begin
            w_state_nxt = decode_seg(w_cand_nxt);
            w_chg_nxt   = (w_state_nxt != r_state);
            if ((w_state_nxt == ST_INV) && (r_err_cnt != ERR_MAX)) begin
                w_err_nxt = r_err_cnt + 8'd1;
            end else begin
                w_err_nxt = r_err_cnt;
            end
        end else begin
            w_state_nxt = r_state;
            w_chg_nxt   = 1'b0;
        end
    end

    // Sample register, candidate/counter and committed state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_q   <= 7'b0000000;
            r_cand    <= 7'b0000000;
            r_cnt     <= CNT_STABLE;
            r_state   <= ST_OFF;
            r_chg     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_seg_q   <= w_seg;
            r_cand    <= w_cand_nxt;
            r_cnt     <= w_cnt_nxt;
            r_state   <= w_state_nxt;
            r_chg     <= w_chg_nxt;
            r_err_cnt <= w_err_nxt;
        end
    end

    assign bus.ch7     = (r_state == ST_POS) || (r_state == ST_ATK);
    assign bus.ch6     = (r_state == ST_ATK);
    assign bus.valid   = (r_state != ST_INV);
    assign bus.chg     = r_chg;
    assign bus.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_segmento_decod_estado.sv
// Bench for segmento_decod_estado: default build (4-sample filter) and a 1-sample build
// share one stimulus stream and are compared against a run-length reference model.
module tb_segmento_decod_estado;

    localparam logic [6:0] P_OFF = 7'b0000000;
    localparam logic [6:0] P_POS = 7'b1100111;
    localparam logic [6:0] P_ATK = 7'b1110111;
    localparam logic [6:0] P_ALL = 7'b1111111;
    localparam logic [6:0] P_ONE = 7'b1000000;
    localparam int         RUN_SAT = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    segmento_decod_estado_if if0 ();
    segmento_decod_estado_if if1 ();

    segmento_decod_estado #(.STABLE_CYCLES(4), .CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    segmento_decod_estado #(.STABLE_CYCLES(1), .CNT_W(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [11:0] o0;
    logic [11:0] o1;
    assign o0 = {if0.ch7, if0.ch6, if0.valid, if0.chg, if0.err_cnt};
    assign o1 = {if1.ch7, if1.ch6, if1.valid, if1.chg, if1.err_cnt};

    // Reference model: a pattern is committed the moment it has been sampled
    // STABLE consecutive times; state 0=blank,1=P,2=A,3=illegal.
    int         m_stable [2] = '{4, 1};
    logic [6:0] m_segq   [2];
    int         m_run    [2];
    int         m_state  [2];
    logic       m_chg    [2];
    int         m_err    [2];

    function automatic int pat_state(input logic [6:0] p);
        if (p == P_OFF) return 0;
        if (p == P_POS) return 1;
        if (p == P_ATK) return 2;
        return 3;
    endfunction

    function automatic logic [11:0] exp_vec(input int u);
        logic on;
        on = (m_state[u] == 1) || (m_state[u] == 2);
        return {on, (m_state[u] == 2), (m_state[u] != 3), m_chg[u], 8'(m_err[u])};
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_segq[u]  = P_OFF;
            m_run[u]   = RUN_SAT;
            m_state[u] = 0;
            m_chg[u]   = 1'b0;
            m_err[u]   = 0;
        end
    endtask

    task automatic model_edge(input logic [6:0] s);
        int ns;
        for (int u = 0; u < 2; u++) begin
            if (m_run[u] == m_stable[u]) begin
                ns        = pat_state(m_segq[u]);
                m_chg[u]  = (ns != m_state[u]);
                if (ns == 3 && m_err[u] < 255) m_err[u] = m_err[u] + 1;
                m_state[u] = ns;
            end else begin
                m_chg[u] = 1'b0;
            end
            if (s == m_segq[u]) begin
                if (m_run[u] < RUN_SAT) m_run[u] = m_run[u] + 1;
            end else begin
                m_run[u] = 1;
            end
            m_segq[u] = s;
        end
    endtask

    task automatic drive(input logic [6:0] s);
        {if0.a, if0.b, if0.c, if0.d, if0.e, if0.f, if0.g} = s;
        {if1.a, if1.b, if1.c, if1.d, if1.e, if1.f, if1.g} = s;
    endtask

    task automatic tick(input logic [6:0] s);
        drive(s);
        @(posedge clk);
        model_edge(s);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        drive(P_OFF);
        #2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o0 !== 12'h200) begin
            failures++;
            $display("FAIL reset_dut4 got=%h exp=%h", o0, 12'h200);
        end
        checks++;
        if (o1 !== 12'h200) begin
            failures++;
            $display("FAIL reset_dut1 got=%h exp=%h", o1, 12'h200);
        end
        for (int i = 1; i <= 6; i++) begin
            tick(P_OFF);
            checks++;
            if (o0 !== 12'h200) begin
                failures++;
                $display("FAIL off_after_reset cyc=%0d got=%h exp=%h", i, o0, 12'h200);
            end
        end
    endtask

    task automatic test_pos_commit();
        logic [11:0] e;
        for (int i = 1; i <= 6; i++) begin
            tick(P_POS);
            e = (i < 5) ? 12'h200 : ((i == 5) ? 12'hB00 : 12'hA00);
            checks++;
            if (o0 !== e) begin
                failures++;
                $display("FAIL pos_commit edge=%0d got=%h exp=%h", i, o0, e);
            end
        end
    endtask

    task automatic test_atk_hold();
        logic [11:0] e;
        for (int i = 1; i <= 25; i++) begin
            tick(P_ATK);
            e = (i < 5) ? 12'hA00 : ((i == 5) ? 12'hF00 : 12'hE00);
            checks++;
            if (o0 !== e) begin
                failures++;
                $display("FAIL atk_hold edge=%0d got=%h exp=%h", i, o0, e);
            end
        end
    endtask

    task automatic test_glitch();
        logic [11:0] e;
        for (int i = 1; i <= 8; i++) begin
            tick((i <= 2) ? P_OFF : P_ATK);
            checks++;
            if (o0 !== 12'hE00) begin
                failures++;
                $display("FAIL glitch_filtered edge=%0d got=%h exp=%h", i, o0, 12'hE00);
            end
        end
        for (int i = 1; i <= 6; i++) begin
            tick(P_OFF);
            e = (i < 5) ? 12'hE00 : ((i == 5) ? 12'h300 : 12'h200);
            checks++;
            if (o0 !== e) begin
                failures++;
                $display("FAIL to_off edge=%0d got=%h exp=%h", i, o0, e);
            end
        end
    endtask

    task automatic test_illegal_sat();
        logic [11:0] e;
        int          ex;
        for (int i = 1; i <= 5; i++) begin
            tick(P_ALL);
            e = (i < 5) ? 12'h200 : 12'h101;
            checks++;
            if (o0 !== e) begin
                failures++;
                $display("FAIL illegal_first edge=%0d got=%h exp=%h", i, o0, e);
            end
        end
        for (int i = 1; i <= 5; i++) begin
            tick(P_ONE);
            e = (i < 5) ? 12'h001 : 12'h002;
            checks++;
            if (o0 !== e) begin
                failures++;
                $display("FAIL inv_to_inv edge=%0d got=%h exp=%h", i, o0, e);
            end
        end
        ex = 2;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 5; i++) tick((k % 2 == 0) ? P_ALL : P_ONE);
            if (ex < 255) ex++;
            checks++;
            if (o0 !== {4'b0000, 8'(ex)}) begin
                failures++;
                $display("FAIL err_saturate run=%0d got=%h exp=%h", k, o0, {4'b0000, 8'(ex)});
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] e;
        for (int i = 0; i < 6; i++) tick(P_ATK);
        for (int i = 0; i < 3; i++) tick(P_POS);
        checks++;
        if (o0 !== 12'hEFF) begin
            failures++;
            $display("FAIL pre_reset_state got=%h exp=%h", o0, 12'hEFF);
        end
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (o0 !== 12'h200) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", o0, 12'h200);
        end
        #3;
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick(P_POS);
            e = (i < 5) ? 12'h200 : 12'hB00;
            checks++;
            if (o0 !== e) begin
                failures++;
                $display("FAIL after_release edge=%0d got=%h exp=%h", i, o0, e);
            end
        end
    endtask

    task automatic test_stable_one();
        logic [6:0]  seq [6];
        logic [11:0] ev  [6];
        seq = '{P_POS, P_POS, P_ATK, P_POS, P_POS, P_POS};
        ev  = '{12'h200, 12'hB00, 12'hA00, 12'hF00, 12'hB00, 12'hA00};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(seq[i]);
            checks++;
            if (o1 !== ev[i]) begin
                failures++;
                $display("FAIL stable_one edge=%0d got=%h exp=%h", i + 1, o1, ev[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] p;
        int         len;
        do_reset();
        for (int r = 0; r < 300; r++) begin
            case ($urandom_range(0, 5))
                0:       p = P_OFF;
                1:       p = P_POS;
                2:       p = P_ATK;
                3:       p = P_ALL;
                default: p = 7'($urandom);
            endcase
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                tick(p);
                checks++;
                if (o0 !== exp_vec(0)) begin
                    failures++;
                    $display("FAIL random_dut4 run=%0d got=%h exp=%h", r, o0, exp_vec(0));
                end
                checks++;
                if (o1 !== exp_vec(1)) begin
                    failures++;
                    $display("FAIL random_dut1 run=%0d got=%h exp=%h", r, o1, exp_vec(1));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        drive(P_OFF);
        test_reset();
        test_pos_commit();
        test_atk_hold();
        test_glitch();
        test_illegal_sat();
        test_mid_reset();
        test_stable_one();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/segmento_decod_estado.md
Name: segmento_decod_estado

Overview:
- Receive-side counterpart of the game-state 7-segment encoder. Monitors the seven active-high segment lines (a..g) that show the state letter.
- Filters glitches and decodes a stable pattern back into the two state bits: ch7 = on/off, ch6 = placement (P) / attack (A).
- Flags illegal patterns. Used by the test harness and by the display self-check path to confirm the panel shows the state the controller commanded.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical registered samples required before a pattern is committed; legal range 1..15.
- CNT_W, 4, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a, b, c, d, e, f, g  input  1 each  segment lines, active-high (1 = lit).
- ch7  output  1  decoded on/off bit (1 = display showing a letter).
- ch6  output  1  decoded mode bit (0 = P / placement, 1 = A / attack); 0 whenever ch7 = 0.
- valid  output  1  committed pattern is one of the three legal codes.
- chg  output  1  one-cycle pulse when the committed state changes.
- err_cnt  output  8  saturating count of committed illegal patterns.

Behaviour:
- Legal codes, with seg = {a,b,c,d,e,f,g}:
  - 0000000 = OFF (ch7=0, ch6=0).
  - 1100111 = P (ch7=1, ch6=0).
  - 1110111 = A (ch7=1, ch6=1).
  - Every other code = INV.
- Committed-state register encoding: OFF=00, POS=01, ATK=10, INV=11.
- Outputs are pure functions of the committed state:
  - ch7 = POS or ATK.
  - ch6 = ATK.
  - valid = not INV.
  - In INV: ch7=0, ch6=0.
- Stage 1: seg_q <= {a..g} every edge; there is no other input synchronisation.
- Stage 2, candidate and counter:
  - If seg_q != cand: cand <= seg_q, cnt <= 1.
  - Else if cnt < STABLE_CYCLES: cnt <= cnt+1.
  - Else: hold.
- Commit: on the edge where cnt's next value equals STABLE_CYCLES and its current value does not, state <= decode(cand's next value).
  - chg <= 1 for that one cycle only if the new state differs from the old state; otherwise chg <= 0.
- Latency: a pattern present before edge k and held steady becomes visible on the outputs after edge k+STABLE_CYCLES. With the default, that is 5 clocks after first sampling.
- Glitch filtering: any pattern held for fewer than STABLE_CYCLES samples is never committed. State and chg are unaffected, and the counter restarts on the new pattern.
- One commit per stable run. Holding a pattern indefinitely does not re-commit, re-pulse chg, or re-count errors.
- err_cnt increments by 1 on every commit whose decoded result is INV, including INV->INV after an intervening different illegal pattern. It saturates at 255 and does not wrap.
- A commit to OFF/POS/ATK does not change err_cnt.
- Reset (asynchronous, any time including mid-count):
  - seg_q = 0, cand = 0, cnt = STABLE_CYCLES, state = OFF.
  - Outputs: ch7 = 0, ch6 = 0, valid = 1, chg = 0, err_cnt = 0.
  - An all-off input after reset produces no commit and no chg.
- Release of reset: normal sampling resumes at the first rising clk edge with rst low.
- STABLE_CYCLES = 1: commit occurs on the same edge cand is loaded. Latency is 2 clocks.

Test Plan:
1. Reset, then hold seg=1100111 -> after edge 5: ch7=1, ch6=0, valid=1; chg high for exactly 1 cycle; err_cnt=0.
2. From P, switch to seg=1110111 -> after 5 edges: ch6=1, ch7=1; single chg pulse. Then hold 20 cycles -> no further chg.
3. From A, apply 0000000 for 2 cycles, then back to 1110111 -> state stays ATK, chg never asserts. Then hold 0000000 for 5 cycles -> ch7=0, ch6=0, one chg pulse.
4. Apply illegal 1111111 for 5 cycles -> valid=0, ch7=0, err_cnt=1. Then 1000000 for 5 cycles -> err_cnt=2, chg=0 (INV->INV). Repeat alternating 300 times -> err_cnt stays at 255.
5. Mid-count reset: apply 1100111 and assert rst asynchronously between edges 3 and 4 -> outputs return to OFF/0 immediately with no clock needed. After release, the pattern still present commits only after 5 more edges.
6. STABLE_CYCLES=1 build: seg=1100111 -> ch7=1 after edge 2. A 1-cycle glitch to 1110111 commits ATK, then P again, giving two chg pulses.
